// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ready and fills the
// IF/ID register, with one-entry hold buffer for decoder back-pressure.
//   state | meaning
//   FETCH | request outstanding at pc, waiting for imem_ready
//   HOLD  | word parked in hold buffer until the IF/ID slot frees up
//   DROP  | wrong-path request still in flight; its data is discarded
module instruction_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_flag_id_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] inst_out,
  output logic [4:0]  inst_read_reg_addr1,
  output logic [4:0]  inst_read_reg_addr2,
  output logic [4:0]  rd,
  output logic [15:0] inst_imm_field,
  output logic [31:0] pc_plus4_out,
  output logic        stall_flag_if_out
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        bubble_q, bubble_d;

  logic        slot_free;
  logic        accept;
  logic        load_en;
  logic [31:0] load_word;
  logic [31:0] pc_inc;

  always_comb begin
    slot_free = bubble_q | ~stall_flag_id_in;
    imem_req  = reset & ((state_q == S_FETCH) | (state_q == S_DROP));
    // DROP keeps presenting the wrong-path address so the request completes unchanged.
    imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
    accept    = imem_req & imem_ready;
    pc_inc    = pc_q + 32'd4;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_d      = hold_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    bubble_d    = bubble_q;
    load_en     = 1'b0;
    load_word   = imem_rdata;

    if (branch_taken) begin
      pc_d     = branch_target & ~32'd3;
      bubble_d = 1'b1;
      hold_d   = '0;
      case (state_q)
        S_FETCH: begin
          if (accept) begin
            state_d = S_FETCH;
          end else begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_DROP:  state_d = accept ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept) begin
            if (slot_free) begin
              load_en   = 1'b1;
              load_word = imem_rdata;
            end else begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end else if (slot_free) begin
            bubble_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            load_en   = 1'b1;
            load_word = hold_q;
            state_d   = S_FETCH;
          end
        end
        S_DROP: begin
          if (accept) begin
            state_d = S_FETCH;
          end
          if (slot_free) begin
            bubble_d = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (load_en) begin
        inst_d   = load_word;
        pc4_d    = pc_inc;
        pc_d     = pc_inc;
        bubble_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= PC_RESET;
      drop_addr_q <= '0;
      hold_q      <= '0;
      inst_q      <= '0;
      pc4_q       <= '0;
      bubble_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_q      <= hold_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      bubble_q    <= bubble_d;
    end
  end

  assign inst_out            = inst_q;
  assign inst_read_reg_addr1 = inst_q[25:21];
  assign inst_read_reg_addr2 = inst_q[20:16];
  assign rd                  = inst_q[15:11];
  assign inst_imm_field      = inst_q[15:0];
  assign pc_plus4_out        = pc4_q;
  assign stall_flag_if_out   = bubble_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic, all
// compared against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_flag_id_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst_out;
  logic [4:0]  inst_read_reg_addr1, inst_read_reg_addr2, rd;
  logic [15:0] inst_imm_field;
  logic [31:0] pc_plus4_out;
  logic        stall_flag_if_out;

  // Second instance exercises PC wrap-around from a high reset vector.
  logic        w_req, w_ready, w_stall, w_br;
  logic [31:0] w_addr, w_rdata, w_tgt, w_inst, w_pc4;
  logic [4:0]  w_a1, w_a2, w_rd;
  logic [15:0] w_imm;
  logic        w_bubble;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall_flag_id_in(stall_flag_id_in), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_out(inst_out),
    .inst_read_reg_addr1(inst_read_reg_addr1), .inst_read_reg_addr2(inst_read_reg_addr2),
    .rd(rd), .inst_imm_field(inst_imm_field), .pc_plus4_out(pc_plus4_out),
    .stall_flag_if_out(stall_flag_if_out)
  );

  assign w_ready = w_req;
  assign w_rdata = mem_word(w_addr);
  assign w_stall = 1'b0;
  assign w_br    = 1'b0;
  assign w_tgt   = 32'h0;

  instruction_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata),
    .stall_flag_id_in(w_stall), .branch_taken(w_br),
    .branch_target(w_tgt), .inst_out(w_inst),
    .inst_read_reg_addr1(w_a1), .inst_read_reg_addr2(w_a2),
    .rd(w_rd), .inst_imm_field(w_imm), .pc_plus4_out(w_pc4),
    .stall_flag_if_out(w_bubble)
  );

  // Reference model: pc, parked words, pending wrong-path request, IF/ID contents.
  logic [31:0] m_pc;
  logic [31:0] m_buf[$];
  bit          m_drop;
  logic [31:0] m_drop_addr;
  bit          m_valid;
  logic [31:0] m_inst, m_pc4;
  bit          ov_en = 1'b0;
  logic [31:0] ov_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_buf.delete();
    m_drop = 1'b0;
    m_drop_addr = '0;
    m_valid = 1'b0;
    m_inst = '0;
    m_pc4 = '0;
  endtask

  task automatic check_ifid();
    chk("inst_out", inst_out, m_inst);
    chk("addr1", {27'd0, inst_read_reg_addr1}, {27'd0, m_inst[25:21]});
    chk("addr2", {27'd0, inst_read_reg_addr2}, {27'd0, m_inst[20:16]});
    chk("rd", {27'd0, rd}, {27'd0, m_inst[15:11]});
    chk("imm", {16'd0, inst_imm_field}, {16'd0, m_inst[15:0]});
    chk("pc_plus4", pc_plus4_out, m_pc4);
    chk("bubble", {31'd0, stall_flag_if_out}, {31'd0, !m_valid});
  endtask

  task automatic step(input bit rdy, input bit stl, input bit br, input logic [31:0] tgt);
    bit          mreq, acc, free, have;
    logic [31:0] maddr, word, w;
    mreq  = (m_buf.size() == 0);
    maddr = m_drop ? m_drop_addr : m_pc;
    chk("imem_req", {31'd0, imem_req}, {31'd0, mreq});
    if (mreq) chk("imem_addr", imem_addr, maddr);
    word = ov_en ? ov_word : mem_word(maddr);
    acc  = rdy && mreq;
    imem_ready       = acc;
    imem_rdata       = word;
    stall_flag_id_in = stl;
    branch_taken     = br;
    branch_target    = tgt;
    free = !m_valid || !stl;
    have = 1'b0;
    w    = '0;
    if (br) begin
      if (m_drop) begin
        if (acc) m_drop = 1'b0;
      end else if (mreq && !acc) begin
        m_drop = 1'b1;
        m_drop_addr = m_pc;
      end
      m_buf.delete();
      m_pc = tgt & ~32'd3;
      m_valid = 1'b0;
    end else begin
      if (m_buf.size() != 0) begin
        have = 1'b1;
        w = m_buf[0];
      end else if (acc && m_drop) begin
        m_drop = 1'b0;
      end else if (acc) begin
        have = 1'b1;
        w = word;
      end
      if (have && free) begin
        m_valid = 1'b1;
        m_inst = w;
        m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
        m_buf.delete();
      end else if (have) begin
        if (m_buf.size() == 0) m_buf.push_back(w);
      end else if (free) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    imem_ready   = 1'b0;
    branch_taken = 1'b0;
    check_ifid();
  endtask

  task automatic do_reset(input bit late_rdy);
    reset = 1'b0;
    branch_taken = 1'b0;
    stall_flag_id_in = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("rst_req_now", {31'd0, imem_req}, 32'd0);
    imem_ready = late_rdy;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    imem_ready = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    model_reset();
    check_ifid();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall_flag_id_in = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    model_reset();

    // Reset, then straight-line fetch; wrap instance checked alongside.
    do_reset(1'b0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t1_pc4_first", pc_plus4_out, 32'd4);
    chk("t1_bubble_first", {31'd0, stall_flag_if_out}, 32'd0);
    chk("wrap_pc4_first", w_pc4, 32'h0000_0000);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    chk("wrap_inst_first", w_inst, mem_word(32'hFFFF_FFFC));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc4_second", w_pc4, 32'd4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t1_pc4_third", pc_plus4_out, 32'd12);

    // Field slicing of a known R-type word.
    ov_en = 1'b1;
    ov_word = 32'h012A_4020;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    ov_en = 1'b0;
    chk("t2_addr1", {27'd0, inst_read_reg_addr1}, 32'd9);
    chk("t2_addr2", {27'd0, inst_read_reg_addr2}, 32'd10);
    chk("t2_rd", {27'd0, rd}, 32'd8);
    chk("t2_imm", {16'd0, inst_imm_field}, 32'h4020);
    chk("t2_inst", inst_out, 32'h012A_4020);

    // Decoder stall: IF/ID holds, next word parks, request drops.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_req_hold", {31'd0, imem_req}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_inst_held", inst_out, 32'h012A_4020);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_buffered_loaded", inst_out, mem_word(32'd16));

    // Redirect while a request is outstanding.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("t4_addr_unchanged", imem_addr, 32'd20);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_addr_target", imem_addr, 32'h0000_0100);
    chk("t4_bubble", {31'd0, stall_flag_if_out}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_pc4", pc_plus4_out, 32'h0000_0104);

    // Reset in the middle of an outstanding request, late ready ignored.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset(1'b1);
    chk("t6_addr_after", imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
